// File: rtl/seg_pkg.sv
// Shared constants, payload type and helpers for the 7-segment scan controller.
package seg_pkg;

  localparam int unsigned SEG_DIGITS_DEF = 4;
  localparam int unsigned SCAN_DIV_DEF   = 50000;
  localparam int unsigned GUARD_DEF      = 16;
  localparam int unsigned MAX_DIGITS     = 8;
  localparam int unsigned NIB_W          = 4;
  localparam int unsigned DATA_MAX_W     = NIB_W * MAX_DIGITS;

  // Display word sized for the widest build; unused upper nibbles stay zero.
  typedef struct packed {
    logic                  hex;
    logic [DATA_MAX_W-1:0] nibs;
  } disp_word_t;

  function automatic logic [MAX_DIGITS-1:0] AN_OFF();
    return '1;
  endfunction

  function automatic logic [NIB_W-1:0] nibble(input logic [DATA_MAX_W-1:0] nibs,
                                              input logic [2:0]            i);
    return nibs[NIB_W*i +: NIB_W];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Data/strobe and display-side signals of the scan controller.
interface seg_scan_ctrl_if #(
  parameter int unsigned DIGITS = seg_pkg::SEG_DIGITS_DEF
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic                  hex_mode_in;
  logic                  lz_blank;
  logic [3:0]            digit;
  logic                  sel;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output load, data_in, hex_mode_in, lz_blank,
    input  digit, sel, an, frame_done
  );

  modport slave (
    input  load, data_in, hex_mode_in, lz_blank,
    output digit, sel, an, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl_prescaler.sv
// Modulo-SCAN_DIV slot counter; tick_c marks the terminal count.
module scan_prescaler
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF,
  localparam int unsigned CNT_W   = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             tick_c
);

  assign tick_c = (cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode display scanner with frame-synchronous update,
// anode guard interval and leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = SEG_DIGITS_DEF,
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF,
  parameter int unsigned GUARD    = GUARD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(DIGITS);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt_c;
  logic              tick_c;
  logic              wrap_c;
  logic              guard_c;
  logic              blank_c;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt_c;
  disp_word_t        shadow;
  disp_word_t        active;
  disp_word_t        load_word_c;
  disp_word_t        shadow_nxt_c;
  disp_word_t        active_nxt_c;
  logic [DIGITS-1:0] an_nxt_c;

  scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .cnt    (cnt),
    .tick_c (tick_c)
  );

  // Outputs are registered from the post-edge state, so decode from next values.
  always_comb begin
    load_word_c  = '{hex: bus.hex_mode_in, nibs: DATA_MAX_W'(bus.data_in)};
    wrap_c       = tick_c && (idx == IDX_W'(DIGITS - 1));
    cnt_nxt_c    = tick_c ? '0 : cnt + CNT_W'(1);
    idx_nxt_c    = idx;
    if (tick_c) begin
      idx_nxt_c = wrap_c ? '0 : idx + IDX_W'(1);
    end
    shadow_nxt_c = bus.load ? load_word_c : shadow;
    active_nxt_c = active;
    if (wrap_c) begin
      active_nxt_c = bus.load ? load_word_c : shadow;
    end
    // cnt < GUARD written as cnt+1 <= GUARD so GUARD=0 is not a degenerate compare.
    guard_c      = (32'(cnt_nxt_c) + 32'd1) <= GUARD;
    blank_c      = bus.lz_blank && (idx_nxt_c != '0) &&
                   ((active_nxt_c.nibs >> (NIB_W * idx_nxt_c)) == '0);
    an_nxt_c     = ~(DIGITS'(1) << idx_nxt_c);
    if (guard_c || blank_c) begin
      an_nxt_c = DIGITS'(AN_OFF());
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx            <= '0;
      shadow         <= '0;
      active         <= '0;
      bus.digit      <= '0;
      bus.sel        <= 1'b0;
      bus.an         <= DIGITS'(AN_OFF());
      bus.frame_done <= 1'b0;
    end else begin
      idx            <= idx_nxt_c;
      shadow         <= shadow_nxt_c;
      active         <= active_nxt_c;
      bus.digit      <= nibble(active_nxt_c.nibs, 3'(idx_nxt_c));
      bus.sel        <= active_nxt_c.hex;
      bus.an         <= an_nxt_c;
      bus.frame_done <= wrap_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: DIGITS=4, SCAN_DIV=8, GUARD=2 plus a GUARD=0 build.
module tb_seg_scan_ctrl;

  logic  clk;
  logic  rst;
  int    checks;
  int    failures;
  string phase;

  seg_scan_ctrl_if #(.DIGITS(4)) bus  ();
  seg_scan_ctrl_if #(.DIGITS(4)) bus2 ();

  seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(8), .GUARD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(8), .GUARD(0)) dut_g0 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Entered at cnt=7 of the previous slot; walks one full slot of the GUARD=2 DUT.
  task automatic run_slot(input int slot, input logic [3:0] exp_digit, input logic [3:0] exp_an,
                          input logic exp_sel, input int ld_c, input logic [15:0] ld_data,
                          input logic ld_hex);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.load = 1'b0;
      check_eq($sformatf("%s an s%0d c%0d", phase, slot, c), 32'(bus.an),
               (c < 2) ? 32'hF : 32'(exp_an));
      check_eq($sformatf("%s digit s%0d c%0d", phase, slot, c), 32'(bus.digit), 32'(exp_digit));
      check_eq($sformatf("%s sel s%0d c%0d", phase, slot, c), 32'(bus.sel), 32'(exp_sel));
      check_eq($sformatf("%s frame_done s%0d c%0d", phase, slot, c), 32'(bus.frame_done),
               (slot == 0 && c == 0) ? 32'd1 : 32'd0);
      if (c == ld_c) begin
        bus.load        = 1'b1;
        bus.data_in     = ld_data;
        bus.hex_mode_in = ld_hex;
      end
    end
  endtask

  initial begin
    logic [3:0] an_tab [4];
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    bus.load         = 1'b0;
    bus.data_in      = '0;
    bus.hex_mode_in  = 1'b0;
    bus.lz_blank     = 1'b0;
    bus2.load        = 1'b0;
    bus2.data_in     = '0;
    bus2.hex_mode_in = 1'b0;
    bus2.lz_blank    = 1'b0;

    // Reset asserted mid-slot must clear outputs before any clock edge.
    phase = "reset";
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (11) @(negedge clk);
    check_eq("reset pre an", 32'(bus.an), 32'hD);
    #2 rst = 1'b1;
    #1;
    check_eq("reset async an", 32'(bus.an), 32'hF);
    check_eq("reset async digit", 32'(bus.digit), 32'h0);
    check_eq("reset async sel", 32'(bus.sel), 32'h0);
    check_eq("reset async frame_done", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check_eq("reset k0 an", 32'(bus.an), 32'hF);
    check_eq("reset k0 digit", 32'(bus.digit), 32'h0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("reset k%0d an", k), 32'(bus.an), (k < 2) ? 32'hF : 32'hE);
      check_eq($sformatf("reset k%0d digit", k), 32'(bus.digit), 32'h0);
    end

    // Load in slot 2 must not tear the current frame.
    phase = "sync_old";
    run_slot(1, 4'h0, 4'b1101, 1'b0, -1, 16'h0000, 1'b0);
    run_slot(2, 4'h0, 4'b1011, 1'b0,  3, 16'h1234, 1'b1);
    run_slot(3, 4'h0, 4'b0111, 1'b0, -1, 16'h0000, 1'b0);

    phase = "sync_new";
    run_slot(0, 4'h4, 4'b1110, 1'b1, -1, 16'h0000, 1'b0);
    run_slot(1, 4'h3, 4'b1101, 1'b1, -1, 16'h0000, 1'b0);
    run_slot(2, 4'h2, 4'b1011, 1'b1, -1, 16'h0000, 1'b0);
    run_slot(3, 4'h1, 4'b0111, 1'b1,  7, 16'h00A7, 1'b0);

    // Load coinciding with the wrap shows from slot 0 of the new frame.
    phase = "wrap_bypass";
    run_slot(0, 4'h7, 4'b1110, 1'b0, -1, 16'h0000, 1'b0);
    run_slot(1, 4'hA, 4'b1101, 1'b0,  3, 16'h0050, 1'b1);
    run_slot(2, 4'h0, 4'b1011, 1'b0, -1, 16'h0000, 1'b0);
    run_slot(3, 4'h0, 4'b0111, 1'b0, -1, 16'h0000, 1'b0);
    bus.lz_blank = 1'b1;

    phase = "lz_on";
    run_slot(0, 4'h0, 4'b1110, 1'b1, -1, 16'h0000, 1'b0);
    run_slot(1, 4'h5, 4'b1101, 1'b1, -1, 16'h0000, 1'b0);
    run_slot(2, 4'h0, 4'b1111, 1'b1, -1, 16'h0000, 1'b0);
    run_slot(3, 4'h0, 4'b1111, 1'b1, -1, 16'h0000, 1'b0);
    bus.lz_blank = 1'b0;

    phase = "lz_off";
    run_slot(0, 4'h0, 4'b1110, 1'b1, -1, 16'h0000, 1'b0);
    run_slot(1, 4'h5, 4'b1101, 1'b1, -1, 16'h0000, 1'b0);
    run_slot(2, 4'h0, 4'b1011, 1'b1,  3, 16'h0000, 1'b0);
    run_slot(3, 4'h0, 4'b0111, 1'b1, -1, 16'h0000, 1'b0);
    bus.lz_blank = 1'b1;

    phase = "all_zero";
    run_slot(0, 4'h0, 4'b1110, 1'b0, -1, 16'h0000, 1'b0);
    run_slot(1, 4'h0, 4'b1111, 1'b0, -1, 16'h0000, 1'b0);
    run_slot(2, 4'h0, 4'b1111, 1'b0, -1, 16'h0000, 1'b0);
    run_slot(3, 4'h0, 4'b1111, 1'b0, -1, 16'h0000, 1'b0);

    // GUARD=0 build: one anode always low, including cnt=0 of each slot.
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        check_eq($sformatf("g0 an s%0d c%0d", s, c), 32'(bus2.an), 32'(an_tab[s]));
        check_eq($sformatf("g0 onehot s%0d c%0d", s, c), 32'($countones(~bus2.an)), 32'd1);
        check_eq($sformatf("g0 frame_done s%0d c%0d", s, c), 32'(bus2.frame_done),
                 (s == 0 && c == 0) ? 32'd1 : 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
